// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: FSM encoding, BCD digit limits
// and the single-digit next-value rule used by the counters and the display path.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } sw_state_e;

   localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
   localparam logic [3:0] DIGIT_MAX_5 = 4'd5;
   localparam int         NUM_DIGITS  = 6;

   // Index 0 is cs_ones, index 5 is min_tens.
   localparam logic [3:0] DIGIT_LIMIT [NUM_DIGITS] = '{
      DIGIT_MAX_9, DIGIT_MAX_9, DIGIT_MAX_9, DIGIT_MAX_5, DIGIT_MAX_9, DIGIT_MAX_5
   };

   // Out-of-range values roll to zero on the next enable, so a digit always recovers.
   function automatic logic [3:0] digit_next(input logic [3:0] q, input logic en,
                                             input logic clr, input logic [3:0] max);
      logic [3:0] n;
      if (clr) begin
         n = 4'd0;
      end else if (en) begin
         n = (q >= max) ? 4'd0 : q + 4'd1;
      end else begin
         n = q;
      end
      return n;
   endfunction

endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// One BCD digit of the live count; carry is asserted when an enabled step rolls it over.
module bcd_digit_cnt
   import stopwatch_pkg::*;
#(
   parameter logic [3:0] MAX = DIGIT_MAX_9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] value,
   output logic       carry
);

   logic [3:0] value_r;

   // Digit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_r <= 4'd0;
      end else begin
         value_r <= digit_next(value_r, en, clr, MAX);
      end
   end

   assign value = value_r;
   assign carry = en && !clr && (value_r >= MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: run/pause/lap control, six-digit BCD live count (mm:ss.cc)
// and a registered display that can be frozen while the live count keeps running.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter logic WRAP_EN = 1'b1
) (
   input  logic       clk,
   input  logic       sys_rst_n,
   input  logic       tick_in,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] cs_ones,
   output logic [3:0] cs_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       wrap_pulse
);

   sw_state_e        state_r;
   logic             running_r;
   logic             wrap_r;
   logic [23:0]      disp_r;
   logic [3:0]       dig_s [NUM_DIGITS];
   logic [5:0]       en_s;
   logic [5:0]       carry_s;
   logic [23:0]      live_nxt_s;
   logic             counting_s;
   logic             at_max_s;
   logic             sat_s;
   logic             clr_s;

   assign counting_s = tick_in && ((state_r == ST_RUN) || (state_r == ST_LAP));
   assign sat_s      = counting_s && at_max_s && !WRAP_EN;
   assign clr_s      = (state_r == ST_PAUSE) && clear;
   assign en_s       = {carry_s[4:0], counting_s && !sat_s};

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_cnt #(.MAX(DIGIT_LIMIT[i])) u_cnt (
         .clk   (clk),
         .rst_n (sys_rst_n),
         .en    (en_s[i]),
         .clr   (clr_s),
         .value (dig_s[i]),
         .carry (carry_s[i])
      );
   end

   // Terminal-count detect and the value the live count takes at the next edge.
   always_comb begin
      at_max_s   = 1'b1;
      live_nxt_s = 24'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         at_max_s = at_max_s && (dig_s[i] == DIGIT_LIMIT[i]);
         live_nxt_s[4*i +: 4] = digit_next(dig_s[i], en_s[i], clr_s, DIGIT_LIMIT[i]);
      end
   end

   // Control FSM with registered display, run flag and wrap strobe.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r   <= ST_IDLE;
         running_r <= 1'b0;
         wrap_r    <= 1'b0;
         disp_r    <= 24'd0;
      end else begin
         wrap_r <= carry_s[5] || sat_s;
         disp_r <= live_nxt_s;
         if (sat_s) begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start_stop) begin
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end else begin
                     state_r   <= ST_IDLE;
                     running_r <= 1'b0;
                  end
               end
               ST_RUN: begin
                  if (start_stop) begin
                     state_r   <= ST_PAUSE;
                     running_r <= 1'b0;
                  end else if (lap) begin
                     state_r   <= ST_LAP;
                     running_r <= 1'b1;
                  end else begin
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end
               end
               ST_LAP: begin
                  if (start_stop) begin
                     state_r   <= ST_PAUSE;
                     running_r <= 1'b0;
                  end else if (lap) begin
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end else begin
                     // Staying in LAP keeps the frozen display.
                     state_r   <= ST_LAP;
                     running_r <= 1'b1;
                     disp_r    <= disp_r;
                  end
               end
               ST_PAUSE: begin
                  if (clear) begin
                     state_r   <= ST_IDLE;
                     running_r <= 1'b0;
                  end else if (start_stop) begin
                     state_r   <= ST_RUN;
                     running_r <= 1'b1;
                  end else begin
                     state_r   <= ST_PAUSE;
                     running_r <= 1'b0;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  running_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cs_ones    = disp_r[3:0];
   assign cs_tens    = disp_r[7:4];
   assign sec_ones   = disp_r[11:8];
   assign sec_tens   = disp_r[15:12];
   assign min_ones   = disp_r[19:16];
   assign min_tens   = disp_r[23:20];
   assign running    = running_r;
   assign wrap_pulse = wrap_r;

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter: WRAP_EN, 1, 1 = wrap 59:59.99 to 00:00.00; 0 = saturate and pause.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 sys_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 tick_in  input  1  gated 100 Hz count pulse, one clk wide, from the upstream gating stage.
REQ-005 start_stop  input  1  debounced key pulse, one clk wide; toggles run/pause.
REQ-006 clear  input  1  debounced key pulse, one clk wide; zeroes count when paused.
REQ-007 lap  input  1  debounced key pulse, one clk wide; freezes/releases display.
REQ-008 cs_ones, cs_tens  output  4 each  displayed centiseconds, BCD.
REQ-009 sec_ones, sec_tens  output  4 each  displayed seconds, BCD (tens 0-5).
REQ-010 min_ones, min_tens  output  4 each  displayed minutes, BCD (tens 0-5).
REQ-011 running  output  1  high in RUN or LAP.
REQ-012 wrap_pulse  output  1  one-clk pulse when the count passes 59:59.99.

Function
REQ-013 States: IDLE, RUN, PAUSE, LAP; one registered state.
REQ-014 IDLE: start_stop -> RUN; clear and lap ignored.
REQ-015 RUN: start_stop -> PAUSE; lap -> LAP (display latched); clear ignored.
REQ-016 LAP: lap -> RUN (display tracks live count); start_stop -> PAUSE (display tracks live count); clear ignored.
REQ-017 PAUSE: start_stop -> RUN; clear -> IDLE with live count zeroed; lap ignored.
REQ-018 Simultaneous key pulses: priority clear > start_stop > lap; lower ones dropped that cycle.
REQ-019 Live count increments by 0.01 s on each tick_in seen while current (pre-transition) state is RUN or LAP; tick coincident with RUN->PAUSE still counts.
REQ-020 Digit chain: cs_ones 0-9, cs_tens 0-9, sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5; each digit advances only on carry from all lower digits.
REQ-021 Digits never hold non-BCD or out-of-range values.
REQ-022 At 59:59.99 with counting tick: WRAP_EN=1 -> 00:00.00, state unchanged; WRAP_EN=0 -> hold 59:59.99, state -> PAUSE; wrap_pulse high next cycle in both cases.
REQ-023 Displayed outputs registered: one clk latency from tick_in to display change outside LAP.
REQ-024 In LAP, display holds the value latched on the LAP entry edge; live count keeps running.
REQ-025 Leaving LAP, display shows live count in the next cycle.
REQ-026 running is a registered decode of state, valid the cycle after transition.

Reset
REQ-027 sys_rst_n low: state IDLE, live count, latched display and all digit outputs 0, running 0, wrap_pulse 0, immediately, without waiting for clk.
REQ-028 Reset mid-count or mid-LAP discards all values; first edge after release behaves as IDLE.

Structure
REQ-029 Package stopwatch_pkg holds the state encoding and digit limit constants (9, 5).
REQ-030 One sub-module bcd_digit_cnt: parameterised max, inputs en/clr, outputs 4-bit value and carry; six instances chained.

Verification
REQ-031 Reset release, start_stop, 100 ticks -> display 00:01.00, running 1.
REQ-032 RUN at 00:00.57, start_stop and tick same cycle -> 00:00.58 then frozen, running 0; clear -> 00:00.00, IDLE.
REQ-033 RUN at 00:12.34, lap, 50 ticks -> display stays 00:12.34; lap -> next cycle 00:12.84.
REQ-034 WRAP_EN=1 at 59:59.99, tick -> 00:00.00, one wrap_pulse, still running; WRAP_EN=0 -> holds 59:59.99, PAUSE.
REQ-035 PAUSE, clear and start_stop same cycle -> IDLE, 00:00.00, running 0.
REQ-036 Assert sys_rst_n low between clk edges during LAP -> all outputs 0 before next edge.
